// File: rtl/tick_mon_pkg.sv
// Shared types and constants for the tick period monitor.
// No logic; constants only.
// No flow control.
package tick_mon_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } mon_state_t;

    localparam int                   ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/tick_edge_det.sv
// Tick rising-edge detector with once-per-pulse over-width flag.
// rise/wide are combinational from tick and one cycle of registered history.
// No backpressure: tick is sampled every cycle.
module tick_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    output logic rise,
    output logic wide
);

    logic tick_q;
    logic wide_q;

    // Remember last tick sample, and whether the current pulse was already flagged wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
            wide_q <= 1'b0;
        end else begin
            tick_q <= tick;
            if (!tick) begin
                wide_q <= 1'b0;
            end else if (tick_q) begin
                wide_q <= 1'b1;
            end
        end
    end

    assign rise = tick & ~tick_q;
    // Second consecutive high sample of a pulse; later high samples of the same pulse are ignored.
    assign wide = tick & tick_q & ~wide_q;

endmodule

// File: rtl/tick_period_monitor.sv
// Checks tick-to-tick interval against PERIOD+/-TOL, locks after LOCK_CNT good periods.
// All outputs registered; error pulses and locked change one cycle after the sampling edge.
// No backpressure: tick is observed every cycle and cannot be stalled.
module tick_period_monitor
    import tick_mon_pkg::*;
#(
    parameter int PERIOD   = 50001,
    parameter int TOL      = 0,
    parameter int LOCK_CNT = 2,
    parameter int CBITS    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 clr,
    output logic                 locked,
    output logic                 err_early,
    output logic                 err_late,
    output logic                 err_width,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [CBITS-1:0]     period_last
);

    localparam int               GW     = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [CBITS-1:0] WIN_LO = CBITS'(PERIOD - TOL);
    localparam logic [CBITS-1:0] WIN_HI = CBITS'(PERIOD + TOL);
    localparam logic [CBITS-1:0] CNT_MAX = '1;
    localparam logic [GW-1:0]    GOOD_TARGET = GW'(LOCK_CNT);

    if (PERIOD + TOL >= (1 << CBITS)) begin : g_cbits_check
        $error("tick_period_monitor: CBITS too narrow for PERIOD+TOL");
    end
    if (PERIOD - TOL < 2) begin : g_window_check
        $error("tick_period_monitor: PERIOD-TOL must be at least 2");
    end
    if (LOCK_CNT < 1) begin : g_lock_check
        $error("tick_period_monitor: LOCK_CNT must be at least 1");
    end

    mon_state_t       state, state_d;
    logic [CBITS-1:0] cnt, cnt_d;
    logic [GW-1:0]    gcnt, gcnt_d;
    logic             rise, wide;
    logic             early, late, width_err, any_err;

    tick_edge_det u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .rise  (rise),
        .wide  (wide)
    );

    // Next state, interval counter and error conditions for this sample.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        gcnt_d  = gcnt;
        early   = 1'b0;
        late    = 1'b0;
        case (state)
            SEARCH: begin
                cnt_d  = '0;
                gcnt_d = '0;
                if (rise) begin
                    state_d = ACQUIRE;
                    cnt_d   = CBITS'(1);
                end
            end
            ACQUIRE, LOCKED: begin
                if (rise) begin
                    cnt_d = CBITS'(1);
                    if (cnt < WIN_LO) begin
                        early   = 1'b1;
                        state_d = ACQUIRE;
                        gcnt_d  = '0;
                    end else if (state == ACQUIRE) begin
                        // Counter never passes WIN_HI here: timeout fires first.
                        if (gcnt + GW'(1) == GOOD_TARGET) begin
                            state_d = LOCKED;
                            gcnt_d  = '0;
                        end else begin
                            gcnt_d = gcnt + GW'(1);
                        end
                    end
                end else if (cnt == WIN_HI) begin
                    late    = 1'b1;
                    state_d = SEARCH;
                    cnt_d   = '0;
                    gcnt_d  = '0;
                end else if (cnt != CNT_MAX) begin
                    cnt_d = cnt + CBITS'(1);
                end
            end
            default: begin
                state_d = SEARCH;
                cnt_d   = '0;
                gcnt_d  = '0;
            end
        endcase
    end

    // Width errors are only meaningful once the monitor is tracking the tick.
    assign width_err = wide & (state != SEARCH);
    assign any_err   = early | late | width_err;

    // State, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SEARCH;
            cnt         <= '0;
            gcnt        <= '0;
            locked      <= 1'b0;
            err_early   <= 1'b0;
            err_late    <= 1'b0;
            err_width   <= 1'b0;
            err_cnt     <= '0;
            period_last <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            gcnt      <= gcnt_d;
            locked    <= (state_d == LOCKED);
            err_early <= early;
            err_late  <= late;
            err_width <= width_err;
            if (rise && (state != SEARCH)) begin
                period_last <= cnt;
            end
            if (clr) begin
                err_cnt <= any_err ? ERR_CNT_W'(1) : '0;
            end else if (any_err && (err_cnt != ERR_CNT_MAX)) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

endmodule
